fetch_ctrl: RTL and testbench

Instruction-fetch controller between the PC/fetch datapath and the instruction memory port. Owns the program counter, issues one outstanding read at a time over a request/grant/response handshake, buffers returned instructions in a 2-entry queue toward decode, and handles redirects (branch/jump) by flushing queued and in-flight fetches. Sits inside `pd1` in place of a free-running fetch, feeding decode via a valid/ready interface.

---
 rtl/fetch_ctrl_if.sv | 36 +++
 rtl/fetch_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Bundles the instruction-memory port and the decode-side queue port of fetch_ctrl.
// Signal names keep the controller's point of view (_o driven by fetch_ctrl, _i driven toward it).
interface fetch_ctrl_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    // Handshakes: a memory request transfers on a cycle where imem_req_o && imem_gnt_i;
    // the response transfers on a cycle with imem_rvalid_i (always accepted).
    // A decode transfer happens on a cycle where insn_valid_o && insn_ready_i; while
    // insn_valid_o is high and insn_ready_i low, pc_o/insn_o are held stable.
    logic              imem_req_o;
    logic [AWIDTH-1:0] imem_addr_o;
    logic              imem_gnt_i;
    logic              imem_rvalid_i;
    logic [DWIDTH-1:0] imem_rdata_i;
    logic              redirect_i;
    logic [AWIDTH-1:0] redirect_pc_i;
    logic              halt_i;
    logic              insn_valid_o;
    logic              insn_ready_i;
    logic [AWIDTH-1:0] pc_o;
    logic [DWIDTH-1:0] insn_o;
    logic              misalign_o;

    modport master (
        output imem_req_o, imem_addr_o, insn_valid_o, pc_o, insn_o, misalign_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
               halt_i, insn_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, insn_valid_o, pc_o, insn_o, misalign_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
               halt_i, insn_ready_i
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, one outstanding imem read, 2-entry queue to decode.
// Optional macro FETCH_CTRL_ALIGN_CHECK_EN adds misaligned-redirect detection and a HALTED state.
module fetch_ctrl #(
    parameter int                 AWIDTH    = 32,
    parameter int                 DWIDTH    = 32,
    parameter logic [AWIDTH-1:0]  BASE_ADDR = 32'h0100_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus,
    output logic [2:0]    dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_FLUSH  = 3'd3
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
        ,
        S_HALTED = 3'd4
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [AWIDTH-1:0] issue_pc_q, issue_pc_d;
    logic              req_q, req_d;

    logic [AWIDTH-1:0] q_pc_q   [2];
    logic [AWIDTH-1:0] q_pc_d   [2];
    logic [DWIDTH-1:0] q_insn_q [2];
    logic [DWIDTH-1:0] q_insn_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic              redirect_act;
    logic [AWIDTH-1:0] redir_pc;
    logic              push_en;
    logic              pop_en;
    logic [1:0]        count_after;

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    logic              misalign_q, misalign_d;
    logic              redir_misaligned;

    assign redir_pc         = bus.redirect_pc_i;
    assign redir_misaligned = (bus.redirect_pc_i[1:0] != 2'b00);
    // Once HALTED, only reset brings the controller back; redirects are ignored.
    assign redirect_act     = bus.redirect_i && (state_q != S_HALTED);
    assign bus.misalign_o   = misalign_q;
`else
    logic              unused_redir_lsb;

    assign redir_pc         = {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
    assign unused_redir_lsb = ^bus.redirect_pc_i[1:0];
    assign redirect_act     = bus.redirect_i;
    assign bus.misalign_o   = 1'b0;
`endif

    // A redirect clears the queue on the same edge, so it overrides any push or pop.
    assign push_en     = (state_q == S_WAIT) && bus.imem_rvalid_i && !redirect_act;
    assign pop_en      = bus.insn_valid_o && bus.insn_ready_i && !redirect_act;
    assign count_after = count_q + {1'b0, push_en} - {1'b0, pop_en};

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        issue_pc_d = issue_pc_q;
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!bus.halt_i && (count_q != 2'd2)) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.imem_gnt_i) begin
                    issue_pc_d = pc_q;
                    pc_d       = pc_q + AWIDTH'(4);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid_i) begin
                    state_d = (!bus.halt_i && (count_after != 2'd2)) ? S_REQ : S_IDLE;
                end
            end
            S_FLUSH: begin
                if (bus.imem_rvalid_i) state_d = S_IDLE;
            end
            default: state_d = state_q;
        endcase

        if (redirect_act) begin
            pc_d = redir_pc;
            case (state_q)
                S_IDLE:  state_d = bus.halt_i ? S_IDLE : S_REQ;
                // A grant in the redirect cycle means a stale response is still owed.
                S_REQ:   state_d = bus.imem_gnt_i ? S_FLUSH : S_REQ;
                S_WAIT:  state_d = bus.imem_rvalid_i ? S_IDLE : S_FLUSH;
                S_FLUSH: state_d = bus.imem_rvalid_i ? S_IDLE : S_FLUSH;
                default: state_d = state_q;
            endcase
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
            if (redir_misaligned) begin
                misalign_d = 1'b1;
                state_d    = S_HALTED;
            end
`endif
        end
    end

    assign req_d = (state_d == S_REQ);

    // ---------------- Instruction queue ----------------
    always_comb begin
        q_pc_d   = q_pc_q;
        q_insn_d = q_insn_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (redirect_act) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_en) begin
                q_pc_d[wr_ptr_q]   = issue_pc_q;
                q_insn_d[wr_ptr_q] = bus.imem_rdata_i;
                wr_ptr_d           = ~wr_ptr_q;
            end
            if (pop_en) rd_ptr_d = ~rd_ptr_q;
            count_d = count_after;
        end
    end

    // ---------------- State registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= BASE_ADDR;
            issue_pc_q  <= '0;
            req_q       <= 1'b0;
            q_pc_q[0]   <= '0;
            q_pc_q[1]   <= '0;
            q_insn_q[0] <= '0;
            q_insn_q[1] <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issue_pc_q  <= issue_pc_d;
            req_q       <= req_d;
            q_pc_q[0]   <= q_pc_d[0];
            q_pc_q[1]   <= q_pc_d[1];
            q_insn_q[0] <= q_insn_d[0];
            q_insn_q[1] <= q_insn_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
`endif

    // ---------------- Outputs ----------------
    assign bus.imem_req_o   = req_q;
    assign bus.imem_addr_o  = pc_q;
    assign bus.insn_valid_o = (count_q != 2'd0);
    assign bus.pc_o         = q_pc_q[rd_ptr_q];
    assign bus.insn_o       = q_insn_q[rd_ptr_q];
    assign dbg_state_o      = state_q;

    // ---------------- Protocol properties ----------------
    a_req_hold: assert property (@(posedge clk) disable iff (!reset)
        (bus.imem_req_o && !bus.imem_gnt_i && !bus.redirect_i)
        |=> (bus.imem_req_o && $stable(bus.imem_addr_o)));

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
        !(push_en && (count_q == 2'd2)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: auto-responding memory (grant same cycle, data next cycle)
// plus hand-driven redirect/halt/reset scenarios with hand-computed expectations.
module tb_fetch_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] BASE = 32'h0100_0000;

  logic clk;
  logic reset;
  logic [2:0] dbg_state;

  fetch_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  fetch_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // memory model state
  bit          mem_auto;
  bit          pend;
  logic [31:0] pend_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: memory inputs are set up from the outputs seen now, then we advance
  // to 1ns past the next rising edge, where outputs are sampled.
  task automatic tick();
    bit          nxt_pend;
    logic [31:0] nxt_addr;
    if (mem_auto) begin
      bus.imem_gnt_i    = bus.imem_req_o;
      bus.imem_rvalid_i = pend;
      bus.imem_rdata_i  = pend ? mem_word(pend_addr) : 32'h0;
    end
    nxt_pend = mem_auto && reset && bus.imem_req_o;
    nxt_addr = bus.imem_addr_o;
    @(posedge clk);
    #1;
    pend      = nxt_pend;
    pend_addr = nxt_addr;
  endtask

  task automatic do_reset();
    reset             = 1'b0;
    mem_auto          = 1'b1;
    pend              = 1'b0;
    pend_addr         = '0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.halt_i        = 1'b0;
    bus.insn_ready_i  = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset values ----------------
    do_reset();
    reset = 1'b0;
    #1;
    check("rst_req",      32'(bus.imem_req_o),   0);
    check("rst_addr",     bus.imem_addr_o,       BASE);
    check("rst_valid",    32'(bus.insn_valid_o), 0);
    check("rst_pc",       bus.pc_o,              0);
    check("rst_insn",     bus.insn_o,            0);
    check("rst_misalign", 32'(bus.misalign_o),   0);
    check("rst_state",    32'(dbg_state),        0);

    // ---------------- streaming fetch, ready high ----------------
    do_reset();
    exp_q = {32'h0100_0000, 32'h0100_0004, 32'h0100_0008};
    tick();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check("str_req",   32'(bus.imem_req_o), 1);
      check("str_addr",  bus.imem_addr_o,     e);
      tick();
      tick();
      check("str_valid", 32'(bus.insn_valid_o), 1);
      check("str_pc",    bus.pc_o,              e);
      check("str_insn",  bus.insn_o,            {e[15:0], 16'hC0DE});
    end

    // ---------------- queue fills with ready low ----------------
    do_reset();
    bus.insn_ready_i = 1'b0;
    repeat (5) tick();
    check("full_valid", 32'(bus.insn_valid_o), 1);
    check("full_pc",    bus.pc_o,              32'h0100_0000);
    check("full_insn",  bus.insn_o,            32'h0000_C0DE);
    for (int k = 0; k < 3; k++) begin
      check("full_req",   32'(bus.imem_req_o), 0);
      check("full_state", 32'(dbg_state),      0);
      tick();
    end
    check("full_hold_pc", bus.pc_o, 32'h0100_0000);
    bus.insn_ready_i = 1'b1;
    tick();
    check("pop1_valid", 32'(bus.insn_valid_o), 1);
    check("pop1_pc",    bus.pc_o,              32'h0100_0004);
    check("pop1_insn",  bus.insn_o,            32'h0004_C0DE);
    check("pop1_req",   32'(bus.imem_req_o),   0);
    tick();
    check("pop2_valid", 32'(bus.insn_valid_o), 0);
    check("resume_req", 32'(bus.imem_req_o),   1);
    check("resume_addr", bus.imem_addr_o,      32'h0100_0008);

    // ---------------- redirect during WAIT ----------------
    do_reset();
    tick();
    tick();
    check("rw_state_wait", 32'(dbg_state), 2);
    mem_auto          = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0100_0100;
    tick();
    check("rw_state_flush", 32'(dbg_state), 3);
    check("rw_req0",        32'(bus.imem_req_o), 0);
    bus.redirect_i    = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    check("rw_drop_valid", 32'(bus.insn_valid_o), 0);
    check("rw_state_idle", 32'(dbg_state), 0);
    bus.imem_rvalid_i = 1'b0;
    tick();
    check("rw_req",  32'(bus.imem_req_o), 1);
    check("rw_addr", bus.imem_addr_o,     32'h0100_0100);
    mem_auto = 1'b1;
    pend     = 1'b0;
    tick();
    tick();
    check("rw_pc",   bus.pc_o,   32'h0100_0100);
    check("rw_insn", bus.insn_o, 32'h0100_C0DE);

    // ---------------- redirect with grant and pop, count 1 ----------------
    do_reset();
    bus.insn_ready_i = 1'b0;
    repeat (3) tick();
    check("rg_pre_valid", 32'(bus.insn_valid_o), 1);
    check("rg_pre_req",   32'(bus.imem_req_o),   1);
    bus.insn_ready_i  = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0100_0200;
    tick();
    check("rg_clr_valid", 32'(bus.insn_valid_o), 0);
    check("rg_flush",     32'(dbg_state),        3);
    bus.redirect_i = 1'b0;
    tick();
    check("rg_drop_valid", 32'(bus.insn_valid_o), 0);
    check("rg_idle",       32'(dbg_state),        0);
    tick();
    check("rg_req",  32'(bus.imem_req_o), 1);
    check("rg_addr", bus.imem_addr_o,     32'h0100_0200);
    tick();
    tick();
    check("rg_pc",   bus.pc_o,   32'h0100_0200);
    check("rg_insn", bus.insn_o, 32'h0200_C0DE);

    // ---------------- halt during WAIT ----------------
    do_reset();
    tick();
    tick();
    bus.halt_i = 1'b1;
    tick();
    check("halt_valid", 32'(bus.insn_valid_o), 1);
    check("halt_pc",    bus.pc_o,              32'h0100_0000);
    for (int k = 0; k < 3; k++) begin
      check("halt_noreq", 32'(bus.imem_req_o), 0);
      tick();
    end
    check("halt_drained", 32'(bus.insn_valid_o), 0);
    bus.halt_i = 1'b0;
    tick();
    check("unhalt_req",  32'(bus.imem_req_o), 1);
    check("unhalt_addr", bus.imem_addr_o,     32'h0100_0004);

    // ---------------- misaligned redirect ----------------
    do_reset();
    tick();
    mem_auto          = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0100_0102;
    tick();
    bus.redirect_i = 1'b0;
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    check("mis_flag",  32'(bus.misalign_o), 1);
    check("mis_state", 32'(dbg_state),      4);
    mem_auto = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("mis_noreq", 32'(bus.imem_req_o), 0);
      tick();
    end
    check("mis_sticky", 32'(bus.misalign_o), 1);
    reset = 1'b0;
    #1;
    check("mis_rst_flag",  32'(bus.misalign_o), 0);
    check("mis_rst_addr",  bus.imem_addr_o,     BASE);
    check("mis_rst_state", 32'(dbg_state),      0);
    reset = 1'b1;
`else
    check("mis_flag0", 32'(bus.misalign_o), 0);
    check("mis_req",   32'(bus.imem_req_o), 1);
    check("mis_addr",  bus.imem_addr_o,     32'h0100_0100);
    mem_auto = 1'b1;
    pend     = 1'b0;
    tick();
    tick();
    check("mis_pc", bus.pc_o, 32'h0100_0100);
`endif

    // ---------------- reset mid-transaction, stale response ----------------
    do_reset();
    tick();
    tick();
    check("mid_wait", 32'(dbg_state), 2);
    mem_auto = 1'b0;
    reset    = 1'b0;
    #1;
    check("mid_rst_state", 32'(dbg_state),      0);
    check("mid_rst_req",   32'(bus.imem_req_o), 0);
    reset             = 1'b1;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b1;
    bus.imem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid_i = 1'b0;
    check("stale_valid", 32'(bus.insn_valid_o), 0);
    check("stale_req",   32'(bus.imem_req_o),   1);
    check("stale_addr",  bus.imem_addr_o,       BASE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
